// File: rtl/rv_bus_pkg.sv
// rtl/rv_bus_pkg.sv - shared types and constants for the mem_bus arbiter
//
// Purpose: arbiter FSM state, grant owner encoding, fetch transfer size and
// helpers that locate the address-map select bits.
// Ports: none (package).

package rv_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RELEASE
    } state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // Instruction fetches are always full 32-bit reads.
    localparam logic [2:0] FETCH_NUM_BYTES = 3'd4;

    // The address MSB selects IO space; the bit below it selects RAM vs flash.
    function automatic int unsigned io_select_bit(input int unsigned address_size);
        return address_size - 1;
    endfunction

    function automatic int unsigned ram_select_bit(input int unsigned address_size);
        return address_size - 2;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - cycle counter that flags a hung bus transaction
//
// Purpose: counts cycles while enabled and reports expiry on the cycle that
// brings the count to TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables expiry.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   i_enable  in   count this cycle (arbiter is in ISSUE)
//   i_clear   in   return count to zero (arbiter outside ISSUE)
//   o_expired out  combinational: this enabled cycle is the last one allowed

module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam logic [31:0] LP_LIMIT = TIMEOUT_CYCLES;

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Expiry fires on the Nth enabled cycle so the requester sees exactly
    // TIMEOUT_CYCLES cycles of bus_start_request before the abort.
    assign o_expired = (LP_LIMIT != 32'd0) && i_enable && ((r_count + 32'd1) == LP_LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing mem_bus between fetch and load/store
//
// Purpose: grants one of two requesters, latches its transaction, drives it on
// mem_bus with a start/done level handshake, and returns data plus a one-cycle
// done pulse. A watchdog aborts transactions that never complete.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_req, i_addr, i_done          fetch requester
//   d_req, d_addr, d_num_bytes,
//   d_is_write, d_write_value,
//   d_done                         load/store requester
//   rsp_value, rsp_error           response, valid with i_done/d_done
//   bus_*                          mem_bus request/response
//   busy                           high in ISSUE and RELEASE

module mem_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 18,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    output logic                    i_done,
    input  logic                    d_req,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [2:0]              d_num_bytes,
    input  logic                    d_is_write,
    input  logic [31:0]             d_write_value,
    output logic                    d_done,
    output logic [31:0]             rsp_value,
    output logic                    rsp_error,
    output logic [ADDRESS_SIZE-1:0] bus_target_address,
    output logic [2:0]              bus_num_bytes,
    output logic                    bus_is_write,
    output logic [31:0]             bus_write_value,
    output logic                    bus_start_request,
    input  logic                    bus_request_done,
    input  logic [31:0]             bus_fetched_value,
    output logic                    busy
);

    state_t r_state;
    state_t w_next_state;
    grant_t r_last_grant;
    grant_t r_owner;
    grant_t w_grant;
    logic   w_grant_valid;
    logic   w_expired;

    logic                    r_i_done;
    logic                    r_d_done;
    logic [31:0]             r_rsp_value;
    logic                    r_rsp_error;
    logic [ADDRESS_SIZE-1:0] r_bus_addr;
    logic [2:0]              r_bus_num_bytes;
    logic                    r_bus_is_write;
    logic [31:0]             r_bus_write_value;
    logic                    r_bus_start;
    logic                    r_busy;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_enable (r_state == ISSUE),
        .i_clear  (r_state != ISSUE),
        .o_expired(w_expired)
    );

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        w_grant_valid = i_req || d_req;
        w_grant       = GRANT_I;
        if (i_req && d_req) begin
            w_grant = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            w_grant = GRANT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // RELEASE waits for the bus to drop done so a stale level is never taken
    // as the completion of the next transaction.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ISSUE;
            ISSUE:   if (bus_request_done || w_expired) w_next_state = RELEASE;
            RELEASE: if (!bus_request_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant      <= GRANT_I;
            r_owner           <= GRANT_I;
            r_i_done          <= 1'b0;
            r_d_done          <= 1'b0;
            r_rsp_value       <= '0;
            r_rsp_error       <= 1'b0;
            r_bus_addr        <= '0;
            r_bus_num_bytes   <= '0;
            r_bus_is_write    <= 1'b0;
            r_bus_write_value <= '0;
            r_bus_start       <= 1'b0;
            r_busy            <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            r_busy   <= (w_next_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_bus_start  <= 1'b1;
                        if (w_grant == GRANT_D) begin
                            r_bus_addr        <= d_addr;
                            r_bus_num_bytes   <= d_num_bytes;
                            r_bus_is_write    <= d_is_write;
                            r_bus_write_value <= d_write_value;
                        end else begin
                            r_bus_addr        <= i_addr;
                            r_bus_num_bytes   <= FETCH_NUM_BYTES;
                            r_bus_is_write    <= 1'b0;
                            r_bus_write_value <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // A real completion takes priority over a same-cycle expiry.
                    if (bus_request_done || w_expired) begin
                        r_bus_start <= 1'b0;
                        r_rsp_value <= bus_request_done ? bus_fetched_value : 32'd0;
                        r_rsp_error <= !bus_request_done;
                        r_i_done    <= (r_owner == GRANT_I);
                        r_d_done    <= (r_owner == GRANT_D);
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_done             = r_i_done;
    assign d_done             = r_d_done;
    assign rsp_value          = r_rsp_value;
    assign rsp_error          = r_rsp_error;
    assign bus_target_address = r_bus_addr;
    assign bus_num_bytes      = r_bus_num_bytes;
    assign bus_is_write       = r_bus_is_write;
    assign bus_write_value    = r_bus_write_value;
    assign bus_start_request  = r_bus_start;
    assign busy               = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_req, i_done, d_req, d_done, d_is_write;
    logic [AW-1:0] i_addr, d_addr, bus_target_address;
    logic [2:0]    d_num_bytes, bus_num_bytes;
    logic [31:0]   d_write_value, rsp_value, bus_write_value, bus_fetched_value;
    logic          rsp_error, bus_is_write, bus_start_request, bus_request_done, busy;

    logic          wd_rst, wd_d_req, wd_i_done, wd_d_done, wd_rsp_error;
    logic          wd_is_write, wd_start, wd_rd, wd_busy;
    logic [AW-1:0] wd_d_addr, wd_addr;
    logic [2:0]    wd_num_bytes;
    logic [31:0]   wd_rsp_value, wd_wv, wd_fv;

    mem_bus_arbiter #(.ADDRESS_SIZE(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_num_bytes(d_num_bytes),
        .d_is_write(d_is_write), .d_write_value(d_write_value), .d_done(d_done),
        .rsp_value(rsp_value), .rsp_error(rsp_error),
        .bus_target_address(bus_target_address), .bus_num_bytes(bus_num_bytes),
        .bus_is_write(bus_is_write), .bus_write_value(bus_write_value),
        .bus_start_request(bus_start_request), .bus_request_done(bus_request_done),
        .bus_fetched_value(bus_fetched_value), .busy(busy)
    );

    mem_bus_arbiter #(.ADDRESS_SIZE(AW), .TIMEOUT_CYCLES(8)) dut_wd (
        .clk(clk), .rst(wd_rst),
        .i_req(1'b0), .i_addr('0), .i_done(wd_i_done),
        .d_req(wd_d_req), .d_addr(wd_d_addr), .d_num_bytes(3'd4),
        .d_is_write(1'b0), .d_write_value(32'd0), .d_done(wd_d_done),
        .rsp_value(wd_rsp_value), .rsp_error(wd_rsp_error),
        .bus_target_address(wd_addr), .bus_num_bytes(wd_num_bytes),
        .bus_is_write(wd_is_write), .bus_write_value(wd_wv),
        .bus_start_request(wd_start), .bus_request_done(wd_rd),
        .bus_fetched_value(wd_fv), .busy(wd_busy)
    );

    typedef struct packed {
        logic        port_d;
        logic [31:0] value;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_lat = 4;
    int   model_hold = 0;

    function automatic logic [31:0] model_fn(input logic [AW-1:0] a);
        return 32'hDEADBFEF ^ {14'd0, a};
    endfunction

    // mem_bus model: answers model_lat cycles after start, holds done until
    // start drops plus model_hold extra cycles; gives up if start vanishes.
    initial begin
        bus_request_done  = 1'b0;
        bus_fetched_value = '0;
        forever begin
            bit aborted;
            int guard;
            @(negedge clk);
            if (bus_start_request && !bus_request_done) begin
                aborted = 1'b0;
                for (int k = 1; k < model_lat; k++) begin
                    @(negedge clk);
                    if (!bus_start_request) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    bus_fetched_value = model_fn(bus_target_address);
                    bus_request_done  = 1'b1;
                    guard = 0;
                    while (bus_start_request && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    repeat (model_hold) @(negedge clk);
                    bus_request_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard consumer: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (i_done || d_done) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: i_done=%0b d_done=%0b rsp=%08h", i_done, d_done, rsp_value);
            end else begin
                e_mon = sb.pop_front();
                if ({d_done, i_done} !== (e_mon.port_d ? 2'b10 : 2'b01) ||
                    rsp_value !== e_mon.value || rsp_error !== e_mon.err) begin
                    miscompares++;
                    $display("FAIL response: got d/i=%0b%0b val=%08h err=%0b, want port_d=%0b val=%08h err=%0b",
                             d_done, i_done, rsp_value, rsp_error, e_mon.port_d, e_mon.value, e_mon.err);
                end
            end
        end
    end

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!(i_done || d_done)) begin
            if (cycles >= limit) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_done: got no done, want done within %0d cycles", limit);
                return;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_start(input int limit, output int cycles);
        cycles = 0;
        while (!bus_start_request) begin
            if (cycles >= limit) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_start: got no start, want start within %0d cycles", limit);
                return;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || bus_request_done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wd_rst = 1'b1;
        i_req = 0; d_req = 0; i_addr = '0; d_addr = '0; d_num_bytes = 3'd4;
        d_is_write = 0; d_write_value = '0;
        wd_d_req = 0; wd_d_addr = '0; wd_rd = 0; wd_fv = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({i_done, d_done, rsp_value, rsp_error, bus_target_address, bus_num_bytes,
             bus_is_write, bus_write_value, bus_start_request, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got start=%0b busy=%0b addr=%05h rsp=%08h, want all 0",
                     bus_start_request, busy, bus_target_address, rsp_value);
        end
        vectors++;
        if ({wd_d_done, wd_start, wd_busy, wd_rsp_error} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_wd: got %04b, want 0000", {wd_d_done, wd_start, wd_busy, wd_rsp_error});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus_start_request !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: got busy=%0b start=%0b, want 0 0", busy, bus_start_request);
        end
    endtask

    task automatic test_fetch();
        int c;
        model_lat = 20;
        i_addr = 18'h00100;
        sb.push_back(exp_t'{1'b0, 32'hDEADBEEF, 1'b0});
        i_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_start_request !== 1'b1 || bus_num_bytes !== 3'd4 || bus_is_write !== 1'b0 ||
            bus_target_address !== 18'h00100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_issue: got start=%0b nb=%0d wr=%0b addr=%05h busy=%0b, want 1 4 0 00100 1",
                     bus_start_request, bus_num_bytes, bus_is_write, bus_target_address, busy);
        end
        wait_done(60, c);
        vectors++;
        if (i_done !== 1'b1 || d_done !== 1'b0 || rsp_value !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL fetch_done: got i=%0b d=%0b val=%08h, want 1 0 deadbeef", i_done, d_done, rsp_value);
        end
        i_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_arbitration();
        int c;
        logic [AW-1:0] want_addr;
        model_lat = 3;
        i_addr = 18'h00200; d_addr = 18'h00300; d_num_bytes = 3'd2; d_is_write = 1'b0;
        for (int k = 0; k < 4; k++)
            sb.push_back(exp_t'{(k % 2 == 0), model_fn((k % 2 == 0) ? 18'h00300 : 18'h00200), 1'b0});
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(20, c);
            vectors++;
            if (c !== ((k == 0) ? 1 : 2)) begin
                miscompares++;
                $display("FAIL rr_gap[%0d]: got %0d cycles to start, want %0d", k, c, (k == 0) ? 1 : 2);
            end
            want_addr = (k % 2 == 0) ? 18'h00300 : 18'h00200;
            vectors++;
            if (bus_target_address !== want_addr || bus_num_bytes !== ((k % 2 == 0) ? 3'd2 : 3'd4)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got addr=%05h nb=%0d, want addr=%05h", k,
                         bus_target_address, bus_num_bytes, want_addr);
            end
            wait_done(20, c);
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_store();
        int c;
        int bad;
        model_lat = 8;
        d_addr = 18'h20010; d_write_value = 32'h41; d_num_bytes = 3'd1; d_is_write = 1'b1;
        sb.push_back(exp_t'{1'b1, model_fn(18'h20010), 1'b0});
        d_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_start_request !== 1'b1 || bus_target_address !== 18'h20010 || bus_num_bytes !== 3'd1 ||
            bus_is_write !== 1'b1 || bus_write_value !== 32'h41) begin
            miscompares++;
            $display("FAIL store_issue: got addr=%05h nb=%0d wr=%0b wv=%08h, want 20010 1 1 00000041",
                     bus_target_address, bus_num_bytes, bus_is_write, bus_write_value);
        end
        d_write_value = 32'hFFFF_FFFF; d_addr = 18'h3FFFF; d_num_bytes = 3'd4; d_is_write = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus_start_request !== 1'b1 || bus_target_address !== 18'h20010 || bus_num_bytes !== 3'd1 ||
                bus_is_write !== 1'b1 || bus_write_value !== 32'h41)
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL store_stable: got %0d unstable cycles, want 0", bad);
        end
        wait_done(20, c);
        d_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_release_hold();
        int c;
        model_lat = 4; model_hold = 3;
        d_addr = 18'h00400; d_num_bytes = 3'd4; d_is_write = 1'b0; i_addr = 18'h00480;
        sb.push_back(exp_t'{1'b1, model_fn(18'h00400), 1'b0});
        sb.push_back(exp_t'{1'b0, model_fn(18'h00480), 1'b0});
        d_req = 1'b1;
        @(negedge clk);
        i_req = 1'b1;
        wait_done(20, c);
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1 || bus_start_request !== 1'b0) begin
                miscompares++;
                $display("FAIL release_hold[%0d]: got busy=%0b start=%0b, want 1 0", k, busy, bus_start_request);
            end
        end
        wait_start(20, c);
        vectors++;
        if (c !== 2 || bus_target_address !== 18'h00480) begin
            miscompares++;
            $display("FAIL release_regrant: got gap=%0d addr=%05h, want 2 00480", c, bus_target_address);
        end
        model_hold = 0;
        wait_done(20, c);
        i_req = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int c;
        model_lat = 30;
        d_addr = 18'h00500;
        d_req = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus_start_request !== 1'b0 || busy !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got start=%0b busy=%0b done=%0b%0b, want 0 0 00",
                     bus_start_request, busy, d_done, i_done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_lat = 3;
        i_addr = 18'h00600; d_addr = 18'h00700;
        sb.push_back(exp_t'{1'b1, model_fn(18'h00700), 1'b0});
        sb.push_back(exp_t'{1'b0, model_fn(18'h00600), 1'b0});
        i_req = 1'b1; d_req = 1'b1;
        wait_start(20, c);
        vectors++;
        if (bus_target_address !== 18'h00700) begin
            miscompares++;
            $display("FAIL tie_after_reset: got addr=%05h, want 00700", bus_target_address);
        end
        wait_done(20, c);
        wait_start(20, c);
        wait_done(20, c);
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();
    endtask

    task automatic wd_normal(input logic [AW-1:0] a, input logic [31:0] v);
        wd_d_addr = a;
        wd_d_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (wd_start !== 1'b1 || wd_addr !== a) begin
            miscompares++;
            $display("FAIL wd_issue: got start=%0b addr=%05h, want 1 %05h", wd_start, wd_addr, a);
        end
        repeat (2) @(negedge clk);
        wd_fv = v; wd_rd = 1'b1;
        @(negedge clk);
        vectors++;
        if (wd_d_done !== 1'b1 || wd_rsp_error !== 1'b0 || wd_rsp_value !== v || wd_start !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_normal_done: got done=%0b err=%0b val=%08h start=%0b, want 1 0 %08h 0",
                     wd_d_done, wd_rsp_error, wd_rsp_value, wd_start, v);
        end
        wd_d_req = 1'b0; wd_rd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int c;
        wd_rst = 1'b0;
        @(negedge clk);
        wd_normal(18'h00040, 32'h1234_5678);
        wd_d_addr = 18'h00080;
        wd_d_req = 1'b1;
        c = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wd_start) c++;
            else break;
        end
        vectors++;
        if (c !== 8) begin
            miscompares++;
            $display("FAIL wd_start_cycles: got %0d, want 8", c);
        end
        vectors++;
        if (wd_d_done !== 1'b1 || wd_rsp_error !== 1'b1 || wd_rsp_value !== 32'd0) begin
            miscompares++;
            $display("FAIL wd_abort: got done=%0b err=%0b val=%08h, want 1 1 00000000",
                     wd_d_done, wd_rsp_error, wd_rsp_value);
        end
        wd_d_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (wd_d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_pulse_width: got done=%0b, want 0", wd_d_done);
        end
        repeat (2) @(negedge clk);
        wd_normal(18'h000C0, 32'hCAFE_0001);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, want finish before 2ms");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store();
        test_release_hold();
        test_reset_mid();
        test_timeout();
        repeat (4) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drained: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
